// File: rtl/score_display.sv
// score_display: BCD conversion of step/time counters onto a blinking, zero-blanked 8-digit scanned display
module score_display #(
   parameter int SCAN_DIV = 100000,
   parameter int BLINK_DIV = 500
) (
   input  logic       clk_d,
   input  logic       rst,
   input  logic [1:0] game_status,
   input  logic [7:0] step_number,
   input  logic [7:0] game_time,
   output logic [7:0] seg,
   output logic [7:0] an
);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t state;
   logic sel, tick, tick_q, phase, won, dark, show;
   logic [7:0] bin, st, glyph;
   logic [11:0] bcd, adj, step_bcd, time_bcd, fld;
   logic [2:0] it, idx, sh;
   logic [1:0] pos;
   logic [3:0] nib;
   logic [SW-1:0] scan_cnt;
   logic [BW-1:0] blink_cnt;
   function automatic logic [7:0] digit7(input logic [3:0] d);
      case (d)
         4'd0: digit7 = 8'h3F;
         4'd1: digit7 = 8'h06;
         4'd2: digit7 = 8'h5B;
         4'd3: digit7 = 8'h4F;
         4'd4: digit7 = 8'h66;
         4'd5: digit7 = 8'h6D;
         4'd6: digit7 = 8'h7D;
         4'd7: digit7 = 8'h07;
         4'd8: digit7 = 8'h7F;
         4'd9: digit7 = 8'h6F;
         default: digit7 = 8'h00;
      endcase
   endfunction
   always_comb begin
      adj = {bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8],
             bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4],
             bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0]};
      tick = scan_cnt == SW'(SCAN_DIV - 1);
      won = game_status == 2'b11;
      dark = won && phase;
      sh = tick_q ? idx : idx - 3'd1;
      pos = sh[2] ? sh[1:0] - 2'd1 : sh[1:0];
      fld = sh[2] ? step_bcd : time_bcd;
      nib = pos == 2'd2 ? fld[11:8] : pos == 2'd1 ? fld[7:4] : fld[3:0];
      show = !dark && (pos == 2'd0 || (pos == 2'd1 && fld[11:4] != 8'd0) || (pos == 2'd2 && fld[11:8] != 4'd0));
      st = game_status == 2'b00 ? 8'h39 : game_status == 2'b01 ? 8'h73 : game_status == 2'b10 ? 8'h40 : 8'h76;
      glyph = sh == 3'd4 ? st : sh == 3'd3 ? 8'h00 : show ? digit7(nib) : 8'h00;
   end
   always_ff @(posedge clk_d) begin
      if (rst) begin
         state <= IDLE;
         sel <= 1'b0;
         bin <= 8'd0;
         bcd <= 12'd0;
         it <= 3'd0;
         step_bcd <= 12'd0;
         time_bcd <= 12'd0;
      end else begin
         case (state)
            IDLE: state <= LOAD;
            LOAD: begin
               bin <= sel ? game_time : step_number;
               bcd <= 12'd0;
               it <= 3'd0;
               state <= SHIFT;
            end
            SHIFT: begin
               {bcd, bin} <= {adj[10:0], bin, 1'b0};
               it <= it + 3'd1;
               if (it == 3'd7) state <= DONE;
            end
            DONE: begin
               if (sel) time_bcd <= bcd;
               else step_bcd <= bcd;
               sel <= ~sel;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_d) begin
      if (rst) begin
         scan_cnt <= '0;
         tick_q <= 1'b0;
         idx <= 3'd0;
         an <= 8'd0;
         seg <= 8'd0;
         blink_cnt <= '0;
         phase <= 1'b0;
      end else begin
         scan_cnt <= tick ? '0 : scan_cnt + SW'(1);
         tick_q <= tick;
         if (tick_q) begin
            idx <= idx + 3'd1;
            an <= 8'd1 << idx;
         end
         seg <= (tick_q || an != 8'd0) ? glyph : 8'h00;
         if (!won) begin
            blink_cnt <= '0;
            phase <= 1'b0;
         end else if (tick) begin
            blink_cnt <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + BW'(1);
            if (blink_cnt == BW'(BLINK_DIV - 1)) phase <= ~phase;
         end
      end
   end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed checks of scan timing, digit map, blanking, blink and conversion commit
module tb_score_display;
   logic clk_d = 1'b0;
   logic rst = 1'b1;
   logic [1:0] game_status = 2'b01;
   logic [7:0] step_number = 8'd255;
   logic [7:0] game_time = 8'd7;
   logic [7:0] seg, an;
   int n_cmp = 0;
   int n_bad = 0;
   score_display #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
      .clk_d(clk_d),
      .rst(rst),
      .game_status(game_status),
      .step_number(step_number),
      .game_time(game_time),
      .seg(seg),
      .an(an)
   );
   always #5 clk_d = ~clk_d;
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int k);
      repeat (k) @(negedge clk_d);
   endtask
   task automatic wait_an(input string tag, input logic [7:0] a, input logic [7:0] e);
      int k;
      k = 0;
      while (an !== a && k < 64) begin
         @(negedge clk_d);
         k++;
      end
      if (an === a) check(tag, seg, e);
      else check({tag, "_timeout"}, an, a);
   endtask
   initial begin
      logic [7:0] e;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         check("rst_an", an, 8'h00);
         check("rst_seg", seg, 8'h00);
      end
      rst = 1'b0;
      cyc(4);
      check("an_pre", an, 8'h00);
      cyc(1);
      check("an_first", an, 8'h01);
      check("seg_first", seg, 8'h3F);
      cyc(30);
      wait_an("t_ones", 8'h01, 8'h07);
      wait_an("t_tens", 8'h02, 8'h00);
      wait_an("t_hund", 8'h04, 8'h00);
      wait_an("blank", 8'h08, 8'h00);
      wait_an("stat_p", 8'h10, 8'h73);
      wait_an("s_ones", 8'h20, 8'h6D);
      wait_an("s_tens", 8'h40, 8'h6D);
      wait_an("s_hund", 8'h80, 8'h5B);
      step_number = 8'd0;
      cyc(40);
      wait_an("z_ones", 8'h20, 8'h3F);
      wait_an("z_tens", 8'h40, 8'h00);
      wait_an("z_hund", 8'h80, 8'h00);
      step_number = 8'd100;
      cyc(40);
      wait_an("h_ones", 8'h20, 8'h3F);
      wait_an("h_tens", 8'h40, 8'h3F);
      wait_an("h_hund", 8'h80, 8'h06);
      wait_an("stat_p2", 8'h10, 8'h73);
      game_status = 2'b11;
      wait_an("bl_s1", 8'h20, 8'h3F);
      wait_an("bl_s10", 8'h40, 8'h00);
      wait_an("bl_s100", 8'h80, 8'h00);
      wait_an("bl_t1", 8'h01, 8'h07);
      wait_an("bl_stat", 8'h10, 8'h76);
      wait_an("bl_s1b", 8'h20, 8'h3F);
      wait_an("bl_s10b", 8'h40, 8'h00);
      game_status = 2'b01;
      cyc(1);
      check("unblink", seg, 8'h3F);
      step_number = 8'd5;
      game_time = 8'd99;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      for (int n = 1; n <= 81; n++) begin
         cyc(1);
         if (n == 5) step_number = 8'd200;
         if (an == 8'h20 || an == 8'h40 || an == 8'h80) begin
            if (n >= 34) e = an == 8'h80 ? 8'h5B : 8'h3F;
            else e = an == 8'h20 ? 8'h6D : 8'h00;
            check("load_hold", seg, e);
         end
      end
      rst = 1'b1;
      cyc(1);
      check("abort_an", an, 8'h00);
      check("abort_seg", seg, 8'h00);
      rst = 1'b0;
      wait_an("clr_ones", 8'h01, 8'h3F);
      wait_an("clr_tens", 8'h02, 8'h00);
      wait_an("rc_ones", 8'h01, 8'h6F);
      wait_an("rc_tens", 8'h02, 8'h6F);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
